mem_wb_stage_reg: RTL and testbench
===================================

# mem_wb_stage_reg

Parametrised MEM/WB pipeline register for the RISC-V core. It sits between the data-memory stage and register-file writeback. It adds the following on top of a plain register:
- a valid bit;
- stall (hold) and flush (bubble) control;
- load-data alignment and sign/zero extension;
- a registered writeback-data select, so downstream needs no mux;
- a retired-instruction counter.

Writeback-enable and data outputs also feed the forwarding unit.

## Interface
Parameters:
- XLEN, 64, datapath width in bits (32 or 64).
- REG_ADDR_W, 5, register-index width.
- CNT_W, 32, retired-counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold all registered state.
- flush  in  1  load a bubble.
- valid  in  1  MEM stage holds a real instruction.
- regwrite  in  1  instruction writes a register.
- memtoreg  in  1  writeback source is memory (load).
- funct3  in  3  load size/sign encoding.
- alures  in  XLEN  ALU result / effective address.
- readmem  in  XLEN  raw aligned doubleword (or word when XLEN=32) read from memory.
- RD  in  REG_ADDR_W  destination register.
- validout  out  1  registered valid.
- regwriteout, memtoregout  out  1  registered controls.
- aluresout  out  XLEN  registered ALU result.
- readmemout  out  XLEN  registered, extended load data.
- RDout  out  REG_ADDR_W  registered destination.
- wbdata  out  XLEN  memtoregout ? readmemout : aluresout.
- wben  out  1  validout & regwriteout & (RDout != 0).
- retired  out  CNT_W  count of valid instructions accepted.

## Operation
Per-edge priority: reset > flush > stall > load.
- **reset:** all registered outputs become 0 (validout, regwriteout, memtoregout, aluresout, readmemout, RDout, retired). Consequently wbdata=0 and wben=0.
- **flush:** same register clear as reset, except retired holds its value.
- **flush with stall:** flush wins.
- **stall:** every register holds, including retired.
- **load:** all fields capture their inputs; validout=valid.
  - When valid=0, regwriteout and memtoregout are forced to 0; data fields still capture their inputs.
  - retired increments by 1 when valid=1 and wraps modulo 2^CNT_W.

Load extension is applied at capture:
- Lane selection:
  - byte: lane = alures[2:0];
  - halfword: lane = alures[2:1];
  - word: lane = alures[2];
  - LD ignores the offset.
- Alignment: lower offset bits are ignored; alignment is enforced upstream.
- funct3 mapping:
  - 000 LB, 001 LH, 010 LW, 011 LD (sign-extended);
  - 100 LBU, 101 LHU, 110 LWU (zero-extended);
  - 111 yields 0.
- When XLEN=32:
  - offset uses alures[1:0];
  - 011 behaves as LW;
  - 110 behaves as LW.
- Extension is applied only when memtoreg=1; otherwise readmemout captures readmem unmodified.

## Timing
- Latency is one cycle, input edge to output.
- All outputs are registered or derived combinationally from registers only. There is no input-to-output combinational path.
- reset, flush and stall are sampled on the same edge as the data.
- Reset asserted mid-stall clears state on that edge.
- Deasserting reset makes the next edge a normal load.
- retired is visible one cycle after the accepting edge.
- Simultaneous retired wrap and flush: flush does not affect retired, so the wrap occurs only on a valid load.

## Structure
- Shared package `rv_pkg`:
  - XLEN default;
  - funct3 load localparams (F3_LB … F3_LWU);
  - REG_ADDR_W.
- Sub-module `load_extend`:
  - combinational;
  - inputs: readmem, offset, funct3;
  - output: extended value;
  - reused by a future load/store unit.
- Top module holds the registers, the priority logic, the counter and the wbdata/wben assignments.

## Test plan
- **Reset:** reset=1 for two cycles with arbitrary inputs -> all outputs 0 and retired=0. After release, valid=1, regwrite=1, RD=5, alures=0x10 -> next cycle RDout=5, wbdata=0x10, wben=1, retired=1.
- **LB sign:** readmem=0x0000_0000_0000_80FF, alures offset=1, funct3=000, memtoreg=1 -> readmemout=0xFFFF_FFFF_FFFF_FF80. Same stimulus with funct3=100 -> 0x80. LW with readmem=0x8000_0000_1234_5678 and offset 4 -> 0xFFFF_FFFF_8000_0000.
- **Stall:** load RD=7 then assert stall for three cycles with new inputs RD=9 -> RDout stays 7 and retired does not change. After release -> RDout=9.
- **Flush over stall:** stall=1 and flush=1 together with validout=1 -> next cycle validout=0, wben=0, retired unchanged.
- **x0 and bubble:** valid=1, regwrite=1, RD=0 -> wben=0, retired increments. valid=0, regwrite=1, RD=3 -> regwriteout=0, wben=0.
- **Wrap:** CNT_W=4, 16 consecutive valid loads -> retired returns to 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RISC-V core constants: datapath widths and load funct3 encodings.
package rv_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CNT_W      = 32;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/load_extend.sv
// Load-data lane selection and sign/zero extension (combinational).
// Works internally on 64 bits and truncates to XLEN, so the XLEN=32
// variant falls out of the same datapath with narrower offsets.
module load_extend #(
    parameter int unsigned XLEN = rv_pkg::XLEN
) (
    input  logic [XLEN-1:0] readmem,
    input  logic [2:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] extended
);
    import rv_pkg::*;

    logic [63:0] rm64;
    logic [2:0]  byte_lane;
    logic [1:0]  half_lane;
    logic        word_lane;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] word_v;
    logic [63:0] res64;

    assign rm64 = 64'(readmem);

    // Lane indices; a 32-bit datapath only uses the low two offset bits
    always_comb begin
        byte_lane = offset;
        half_lane = offset[2:1];
        word_lane = offset[2];
        if (XLEN == 32) begin
            byte_lane = {1'b0, offset[1:0]};
            half_lane = {1'b0, offset[1]};
            word_lane = 1'b0;
        end
    end

    assign byte_v = rm64[{byte_lane, 3'b000} +: 8];
    assign half_v = rm64[{half_lane, 4'b0000} +: 16];
    assign word_v = rm64[{word_lane, 5'b00000} +: 32];

    // Extension per load type; LD and LWU collapse to LW on a 32-bit datapath
    always_comb begin
        res64 = '0;
        case (funct3)
            F3_LB:  res64 = {{56{byte_v[7]}}, byte_v};
            F3_LH:  res64 = {{48{half_v[15]}}, half_v};
            F3_LW:  res64 = {{32{word_v[31]}}, word_v};
            F3_LD:  res64 = (XLEN == 32) ? {{32{word_v[31]}}, word_v} : rm64;
            F3_LBU: res64 = {56'd0, byte_v};
            F3_LHU: res64 = {48'd0, half_v};
            F3_LWU: res64 = {32'd0, word_v};
            default: res64 = '0;
        endcase
    end

    assign extended = XLEN'(res64);

endmodule

// File: rtl/mem_wb_stage_reg.sv
// MEM/WB pipeline register with valid, stall/flush, load extension,
// registered writeback select/enable and a retired-instruction counter.
// wbdata and wben are registered copies of their defining functions so
// the forwarding unit sees only flop outputs.
module mem_wb_stage_reg #(
    parameter int unsigned XLEN       = rv_pkg::XLEN,
    parameter int unsigned REG_ADDR_W = rv_pkg::REG_ADDR_W,
    parameter int unsigned CNT_W      = rv_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  valid,
    input  logic                  regwrite,
    input  logic                  memtoreg,
    input  logic [2:0]            funct3,
    input  logic [XLEN-1:0]       alures,
    input  logic [XLEN-1:0]       readmem,
    input  logic [REG_ADDR_W-1:0] RD,
    output logic                  validout,
    output logic                  regwriteout,
    output logic                  memtoregout,
    output logic [XLEN-1:0]       aluresout,
    output logic [XLEN-1:0]       readmemout,
    output logic [REG_ADDR_W-1:0] RDout,
    output logic [XLEN-1:0]       wbdata,
    output logic                  wben,
    output logic [CNT_W-1:0]      retired
);

    logic [XLEN-1:0] ext_data;
    logic [XLEN-1:0] load_data;
    logic            cap_regwrite;
    logic            cap_memtoreg;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .readmem  (readmem),
        .offset   (alures[2:0]),
        .funct3   (funct3),
        .extended (ext_data)
    );

    // Next-state values for a normal load; bubbles never write or load
    assign load_data    = memtoreg ? ext_data : readmem;
    assign cap_regwrite = valid & regwrite;
    assign cap_memtoreg = valid & memtoreg;

    // Stage register: reset > flush > stall > load
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            validout    <= 1'b0;
            regwriteout <= 1'b0;
            memtoregout <= 1'b0;
            aluresout   <= '0;
            readmemout  <= '0;
            RDout       <= '0;
            wbdata      <= '0;
            wben        <= 1'b0;
        end else if (!stall) begin
            validout    <= valid;
            regwriteout <= cap_regwrite;
            memtoregout <= cap_memtoreg;
            aluresout   <= alures;
            readmemout  <= load_data;
            RDout       <= RD;
            wbdata      <= cap_memtoreg ? load_data : alures;
            wben        <= cap_regwrite & (RD != '0);
        end
    end

    // Retired counter: cleared only by reset, unaffected by flush, wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            retired <= '0;
        end else if (!flush && !stall && valid) begin
            retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// Randomised + directed bench for mem_wb_stage_reg: a 64-bit instance with a
// 4-bit counter and a 32-bit instance share stimulus and are each compared
// against a behavioural model every cycle.
module tb_mem_wb_stage_reg;

    logic        clk = 1'b0;
    logic        reset, stall, flush, valid, regwrite, memtoreg;
    logic [2:0]  funct3;
    logic [63:0] alures, readmem;
    logic [4:0]  RD;

    // 64-bit instance outputs
    logic        v64, rw64, mtr64, wben64;
    logic [63:0] alu64, rm64, wb64;
    logic [4:0]  rd64;
    logic [3:0]  ret64;

    // 32-bit instance outputs
    logic        v32, rw32, mtr32, wben32;
    logic [31:0] alu32, rm32, wb32;
    logic [4:0]  rd32;
    logic [31:0] ret32;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic        v;
        logic        rw;
        logic        mtr;
        logic [63:0] alu;
        logic [63:0] rm;
        logic [4:0]  rd;
        logic [31:0] ret;
    } model_t;

    model_t m64, m32;

    always #5 clk = ~clk;

    mem_wb_stage_reg #(.XLEN(64), .REG_ADDR_W(5), .CNT_W(4)) dut64 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid(valid),
        .regwrite(regwrite), .memtoreg(memtoreg), .funct3(funct3),
        .alures(alures), .readmem(readmem), .RD(RD),
        .validout(v64), .regwriteout(rw64), .memtoregout(mtr64),
        .aluresout(alu64), .readmemout(rm64), .RDout(rd64),
        .wbdata(wb64), .wben(wben64), .retired(ret64)
    );

    mem_wb_stage_reg #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(32)) dut32 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid(valid),
        .regwrite(regwrite), .memtoreg(memtoreg), .funct3(funct3),
        .alures(alures[31:0]), .readmem(readmem[31:0]), .RD(RD),
        .validout(v32), .regwriteout(rw32), .memtoregout(mtr32),
        .aluresout(alu32), .readmemout(rm32), .RDout(rd32),
        .wbdata(wb32), .wben(wben32), .retired(ret32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Load extension from size/sign/byte-offset arithmetic
    function automatic logic [63:0] ext_ref(input int xlen, input logic [2:0] f3,
                                            input logic [63:0] addr, input logic [63:0] rm);
        int          size;
        bit          sgn;
        int          off, start;
        logic [63:0] data, v, mask;
        data = (xlen == 32) ? {32'd0, rm[31:0]} : rm;
        case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: begin size = 4; sgn = 1; end
            3'd3: begin size = (xlen == 32) ? 4 : 8; sgn = 1; end
            3'd4: begin size = 1; sgn = 0; end
            3'd5: begin size = 2; sgn = 0; end
            3'd6: begin size = 4; sgn = 0; end
            default: return 64'd0;
        endcase
        off   = int'(addr[5:0]) % (xlen / 8);
        start = (off / size) * size;
        v     = data >> (8 * start);
        if (size < 8) begin
            mask = (64'd1 << (8 * size)) - 64'd1;
            v    = v & mask;
            if (sgn && v[8 * size - 1]) v = v | ~mask;
        end
        if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    function automatic model_t next_model(input model_t m, input int xlen, input logic [31:0] cmask);
        model_t      n;
        logic [63:0] xm;
        xm = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
        n  = m;
        if (reset) begin
            n = '0;
        end else if (flush) begin
            n     = '0;
            n.ret = m.ret;
        end else if (!stall) begin
            n.v   = valid;
            n.rw  = valid && regwrite;
            n.mtr = valid && memtoreg;
            n.alu = alures & xm;
            n.rm  = memtoreg ? ext_ref(xlen, funct3, alures, readmem) : (readmem & xm);
            n.rd  = RD;
            if (valid) n.ret = (m.ret + 32'd1) & cmask;
        end
        return n;
    endfunction

    task automatic compare_all();
        check("64.validout",    64'(v64),    64'(m64.v));
        check("64.regwriteout", 64'(rw64),   64'(m64.rw));
        check("64.memtoregout", 64'(mtr64),  64'(m64.mtr));
        check("64.aluresout",   alu64,       m64.alu);
        check("64.readmemout",  rm64,        m64.rm);
        check("64.RDout",       64'(rd64),   64'(m64.rd));
        check("64.wbdata",      wb64,        m64.mtr ? m64.rm : m64.alu);
        check("64.wben",        64'(wben64), 64'(m64.v && m64.rw && m64.rd != 5'd0));
        check("64.retired",     64'(ret64),  64'(m64.ret));
        check("32.validout",    64'(v32),    64'(m32.v));
        check("32.regwriteout", 64'(rw32),   64'(m32.rw));
        check("32.memtoregout", 64'(mtr32),  64'(m32.mtr));
        check("32.aluresout",   64'(alu32),  m32.alu);
        check("32.readmemout",  64'(rm32),   m32.rm);
        check("32.RDout",       64'(rd32),   64'(m32.rd));
        check("32.wbdata",      64'(wb32),   m32.mtr ? m32.rm : m32.alu);
        check("32.wben",        64'(wben32), 64'(m32.v && m32.rw && m32.rd != 5'd0));
        check("32.retired",     64'(ret32),  64'(m32.ret));
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        m64 = next_model(m64, 64, 32'h0000_000F);
        m32 = next_model(m32, 32, 32'hFFFF_FFFF);
        #1;
        compare_all();
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic v,
                         input logic rw, input logic mtr, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] rm, input logic [4:0] rd);
        reset = r; stall = s; flush = f; valid = v; regwrite = rw; memtoreg = mtr;
        funct3 = f3; alures = a; readmem = rm; RD = rd;
    endtask

    task automatic drive_random(input logic r, input logic s, input logic f);
        drive(r, s, f, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
    endtask

    initial begin
        m64 = '0;
        m32 = '0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
        #1;

        // Reset for two cycles with arbitrary inputs
        drive_random(1'b1, 1'($urandom), 1'($urandom)); tick();
        drive_random(1'b1, 1'($urandom), 1'($urandom)); tick();
        check("reset.retired", 64'(ret64), 64'd0);
        check("reset.wben",    64'(wben64), 64'd0);

        // First load after reset release
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 64'h10, 64'h0, 5'd5); tick();
        check("first.RDout",   64'(rd64), 64'd5);
        check("first.wbdata",  wb64, 64'h10);
        check("first.wben",    64'(wben64), 64'd1);
        check("first.retired", 64'(ret64), 64'd1);

        // Load extension cases
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 64'h1, 64'h80FF, 5'd1); tick();
        check("lb.sign", rm64, 64'hFFFF_FFFF_FFFF_FF80);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b100, 64'h1, 64'h80FF, 5'd1); tick();
        check("lbu.zero", rm64, 64'h80);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 64'h4, 64'h8000_0000_1234_5678, 5'd1); tick();
        check("lw.hi",   rm64, 64'hFFFF_FFFF_8000_0000);
        check("lw32.lo", 64'(rm32), 64'h1234_5678);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b111, 64'h4, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1); tick();
        check("f3_111", rm64, 64'd0);

        // Stall holds everything
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 64'h77, 64'h0, 5'd7); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 64'h99, 64'h0, 5'd9); tick();
            check("stall.RDout", 64'(rd64), 64'd7);
        end
        check("stall.retired", 64'(ret64), 64'd6);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 64'h99, 64'h0, 5'd9); tick();
        check("unstall.RDout", 64'(rd64), 64'd9);

        // Flush wins over stall, retired untouched
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 64'h5, 64'h0, 5'd4); tick();
        check("flush.validout", 64'(v64), 64'd0);
        check("flush.wben",     64'(wben64), 64'd0);
        check("flush.retired",  64'(ret64), 64'd7);

        // x0 destination and bubble
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 64'h5, 64'h0, 5'd0); tick();
        check("x0.wben",    64'(wben64), 64'd0);
        check("x0.retired", 64'(ret64), 64'd8);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 64'h5, 64'h0, 5'd3); tick();
        check("bubble.regwriteout", 64'(rw64), 64'd0);
        check("bubble.wben",        64'(wben64), 64'd0);

        // Counter wrap after 16 valid loads
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 64'h0, 5'd0); tick();
        for (int i = 0; i < 16; i++) begin
            drive_random(1'b0, 1'b0, 1'b0);
            valid = 1'b1;
            tick();
        end
        check("wrap.retired64", 64'(ret64), 64'd0);
        check("wrap.retired32", 64'(ret32), 64'd16);

        // Randomised traffic, occasional reset/flush, frequent stall
        for (int i = 0; i < 500; i++) begin
            drive_random(1'($urandom_range(0, 31) == 0),
                         1'($urandom_range(0, 3) == 0),
                         1'($urandom_range(0, 9) == 0));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
